mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 64-bit pipelined ARM datapath.
- Sequences each access through a req/ack memory handshake that tolerates variable latency.
- Returns the read data to the requesting port and drives per-stage stall signals into the hazard logic.
- Data port has priority; a streak counter prevents instruction-fetch starvation.

Parameters:
N, 64, address and data width
MAX_STREAK, 4, max consecutive D grants while an I request waits (range 1..15)
TIMEOUT, 255, cycles without m_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
i_req  input  1  fetch request; held stable until i_valid
i_addr  input  N  fetch address
i_rdata  output  32  fetched instruction
i_valid  output  1  one-cycle completion pulse for fetch
d_read  input  1  load request; held until d_valid
d_write  input  1  store request; held until d_valid
d_addr  input  N  data address
d_wdata  input  N  store data
d_rdata  output  N  load data
d_valid  output  1  one-cycle completion pulse for data
m_req  output  1  memory request, registered
m_we  output  1  memory write enable, registered
m_addr  output  N  memory address, registered
m_wdata  output  N  memory write data, registered
m_rdata  input  N  memory read data, valid with m_ack
m_ack  input  1  memory completion, sampled only while m_req=1
if_stall  output  1  i_req & ~i_valid
mem_stall  output  1  (d_read|d_write) & ~d_valid
bus_err  output  1  sticky timeout error (constant 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, active-high):
  - State IDLE; streak counter 0.
  - m_req, m_we, i_valid, d_valid and bus_err all 0.
  - m_addr, m_wdata, i_rdata and d_rdata are 0.
  - An in-flight memory transaction is abandoned without completion.
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE arbitration (per cycle):
  - A port whose valid is high this cycle is ignored.
  - D wins if it is requesting, unless i_req=1 and streak==MAX_STREAK.
  - Otherwise I wins if i_req=1.
  - No request: stay in IDLE.
- Grant edge:
  - Register m_req=1, m_addr and m_wdata from the winner.
  - m_we = d_write for D; m_we = 0 for I.
  - Go to BUSY_x.
- Streak counter:
  - Increments on a D grant when i_req=1.
  - Clears on an I grant, or on a D grant with i_req=0.
  - Saturates at MAX_STREAK.
- BUSY_x:
  - Hold m_req and all m_* outputs stable until m_ack=1.
  - On the ack edge: m_req goes to 0, state goes to IDLE, and the data register is captured.
  - Capture for I: i_rdata = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - Capture for D: d_rdata = m_rdata. On writes d_rdata is unchanged.
  - x_valid=1 in the following cycle only.
- Latency: request seen in IDLE at edge k, m_req high from k, ack at edge k+1 earliest, valid in cycle k+1 to k+2. Minimum is 2 cycles from request to valid.
- Back-to-back: in the valid cycle the arbiter is in IDLE and may grant the other port. The same port can be regranted one cycle later.
- d_read and d_write both high: treated as a write (m_we=1); d_valid pulses normally.
- Requests changing mid-transaction are a requester protocol violation. The latched m_* values are used regardless.
- m_ack while m_req=0 is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY_x, cleared on every grant.
  - If it reaches TIMEOUT with no m_ack: drop m_req, return to IDLE, and pulse x_valid with x_rdata=0.
  - Set bus_err=1, which stays set until reset.
- When undefined:
  - No counter; BUSY_x waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- Single fetch: i_req=1, i_addr=0x104, ack 1 cycle later with m_rdata=0xAAAA_BBBB_CCCC_DDDD -> i_rdata=0xAAAABBBB, i_valid pulses once, if_stall low in the valid cycle.
- Simultaneous: i_req=1 and d_read=1, d_addr=0x40 -> first m_addr=0x40 (D), then I is served in the cycle after d_valid. mem_stall and if_stall track correctly.
- Starvation: d_read held via back-to-back loads with i_req=1, MAX_STREAK=4 -> exactly 4 D grants, then one I grant, then the streak resets.
- Store: d_write=1, d_addr=0x80, d_wdata=0x1234 -> m_we=1, m_wdata=0x1234 held through a 5-cycle ack delay; d_valid pulses; d_rdata is unchanged.
- Async reset asserted mid BUSY_D -> m_req=0 and state IDLE immediately without a clock; no valid pulse afterwards.
- With ARB_TIMEOUT_EN and TIMEOUT=8, ack never arrives -> m_req drops after 8 cycles, d_valid=1 with d_rdata=0, bus_err=1 until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter for one single-ported unified memory, req/ack handshake.
// Optional bus timeout with sticky bus_err is built when ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int N          = 64,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [N-1:0] i_addr,
  output logic [31:0]  i_rdata,
  output logic         i_valid,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_valid,
  output logic         m_req,
  output logic         m_we,
  output logic [N-1:0] m_addr,
  output logic [N-1:0] m_wdata,
  input  logic [N-1:0] m_rdata,
  input  logic         m_ack,
  output logic         if_stall,
  output logic         mem_stall,
  output logic         bus_err
);

  if (N < 64 || MAX_STREAK < 1 || MAX_STREAK > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_arbiter: unsupported parameter value");
  end

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state, state_next;
  logic [3:0] streak;
  logic       i_pend, d_pend;
  logic       grant_i, grant_d, done_i, done_d;
  logic       acked, abort;

  // A port in its completion cycle is not a new request.
  assign i_pend    = i_req & ~i_valid;
  assign d_pend    = (d_read | d_write) & ~d_valid;
  assign acked     = m_ack & m_req;
  assign if_stall  = i_req & ~i_valid;
  assign mem_stall = (d_read | d_write) & ~d_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // Abort after TIMEOUT busy cycles; a coincident ack still wins.
  assign abort = (state != IDLE) && !acked && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (grant_i || grant_d)
        tcnt <= '0;
      else if (state != IDLE)
        tcnt <= tcnt + 1'b1;
      if (abort)
        bus_err <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done_i     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && !(i_pend && streak == STREAK_MAX)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_pend) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I: begin
        if (acked || abort) begin
          done_i     = 1'b1;
          state_next = IDLE;
        end
      end
      BUSY_D: begin
        if (acked || abort) begin
          done_d     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      streak  <= '0;
    end else begin
      i_valid <= done_i;
      d_valid <= done_d;

      if (grant_i || grant_d) begin
        m_req   <= 1'b1;
        m_we    <= grant_d & d_write;
        m_addr  <= grant_d ? d_addr : i_addr;
        m_wdata <= grant_d ? d_wdata : '0;
      end else if (done_i || done_d) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end

      if (done_i)
        i_rdata <= abort ? 32'h0 : (m_addr[2] ? m_rdata[63:32] : m_rdata[31:0]);
      if (done_d && (abort || !m_we))
        d_rdata <= abort ? '0 : m_rdata;

      // Streak counts only D grants that made a waiting fetch lose.
      if (grant_i) begin
        streak <= '0;
      end else if (grant_d) begin
        if (!i_pend)
          streak <= '0;
        else if (streak != STREAK_MAX)
          streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter (ARB_TIMEOUT_EN optional).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read, d_write;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        d_valid;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        m_ack;
  logic        if_stall, mem_stall, bus_err;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.N(64), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .if_stall(if_stall), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit   stable;
    logic exp_we;
    exp_we = v.is_d & v.wr;
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    step;
    chk($sformatf("v%0d m_req", idx), m_req, 1);
    chk($sformatf("v%0d m_addr", idx), m_addr, v.addr);
    chk($sformatf("v%0d m_we", idx), m_we, exp_we);
    if (exp_we) chk($sformatf("v%0d m_wdata", idx), m_wdata, v.wdata);
    chk($sformatf("v%0d stall_busy", idx), v.is_d ? mem_stall : if_stall, 1);
    stable = 1'b1;
    for (int c = 0; c < v.delay; c++) begin
      step;
      if (m_req !== 1'b1 || m_addr !== v.addr || m_we !== exp_we) stable = 1'b0;
      if (v.is_d ? d_valid : i_valid) stable = 1'b0;
    end
    chk($sformatf("v%0d hold", idx), stable, 1);
    m_ack = 1'b1; m_rdata = v.rdata;
    step;
    m_ack = 1'b0;
    chk($sformatf("v%0d valid", idx), v.is_d ? d_valid : i_valid, 1);
    chk($sformatf("v%0d other_valid", idx), v.is_d ? i_valid : d_valid, 0);
    chk($sformatf("v%0d m_req_done", idx), m_req, 0);
    chk($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : {32'h0, i_rdata}, v.exp_rdata);
    chk($sformatf("v%0d stall_valid", idx), v.is_d ? mem_stall : if_stall, 0);
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step;
    chk($sformatf("v%0d valid_once", idx), v.is_d ? d_valid : i_valid, 0);
    chk($sformatf("v%0d idle", idx), m_req, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 64'h104, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 64'hAAAA_BBBB};
    vecs[1] = '{0, 0, 0, 64'h100, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 64'hCCCC_DDDD};
    vecs[2] = '{1, 1, 0, 64'h40, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1, 0, 1, 64'h80, 64'h1234, 64'h0, 5, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1, 1, 1, 64'h88, 64'hFFFF_0000, 64'hDEAD, 1, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{1, 1, 0, 64'h90, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[6] = '{0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h1111_2222_3333_4444, 1, 64'h1111_2222};

    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
    step; step;
    chk("rst m_req", m_req, 0);
    chk("rst m_we", m_we, 0);
    chk("rst valids", {i_valid, d_valid}, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst rdata", {i_rdata, d_rdata[31:0]} | {32'h0, d_rdata[63:32]}, 0);
    reset = 1'b0;
    step;

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Simultaneous requests: D first, then I granted in the d_valid cycle.
    i_req = 1'b1; i_addr = 64'h200; d_read = 1'b1; d_addr = 64'h40;
    step;
    chk("sim first_addr", m_addr, 64'h40);
    chk("sim first_we", m_we, 0);
    chk("sim stalls_busy", {if_stall, mem_stall}, 2'b11);
    m_ack = 1'b1; m_rdata = 64'h5555_6666_7777_8888;
    step;
    m_ack = 1'b0;
    chk("sim d_valid", d_valid, 1);
    chk("sim stalls_dvalid", {if_stall, mem_stall}, 2'b10);
    chk("sim d_rdata", d_rdata, 64'h5555_6666_7777_8888);
    d_read = 1'b0;
    step;
    chk("sim second_req", m_req, 1);
    chk("sim second_addr", m_addr, 64'h200);
    chk("sim d_valid_once", d_valid, 0);
    m_ack = 1'b1; m_rdata = 64'h9999_AAAA_BBBB_CCCC;
    step;
    m_ack = 1'b0;
    chk("sim i_valid", i_valid, 1);
    chk("sim i_rdata", i_rdata, 32'hBBBB_CCCC);
    chk("sim if_stall_ivalid", if_stall, 0);
    i_req = 1'b0;
    step;

    // Starvation: four D grants against a waiting fetch, then I must win.
    for (int g = 0; g < 4; g++) begin
      i_req = 1'b1; i_addr = 64'h300; d_read = 1'b1; d_addr = 64'h1000 + 64'(g * 8);
      step;
      chk($sformatf("stv d_grant%0d", g), m_addr, 64'h1000 + 64'(g * 8));
      m_ack = 1'b1; m_rdata = 64'h1000 + 64'(g);
      step;
      m_ack = 1'b0;
      chk($sformatf("stv d_valid%0d", g), d_valid, 1);
      i_req = 1'b0;
      step;
    end
    i_req = 1'b1; i_addr = 64'h300; d_read = 1'b1; d_addr = 64'h2000;
    step;
    chk("stv i_wins", m_addr, 64'h300);
    m_ack = 1'b1; m_rdata = 64'h0000_0000_1357_9BDF;
    step;
    m_ack = 1'b0;
    chk("stv i_valid", i_valid, 1);
    chk("stv i_rdata", i_rdata, 32'h1357_9BDF);
    i_req = 1'b0;
    step;
    chk("stv d_after_i", m_addr, 64'h2000);
    m_ack = 1'b1; m_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    step;
    m_ack = 1'b0; d_read = 1'b0;
    step;
    i_req = 1'b1; i_addr = 64'h308; d_read = 1'b1; d_addr = 64'h2008;
    step;
    chk("stv streak_reset", m_addr, 64'h2008);
    m_ack = 1'b1; m_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    step;
    m_ack = 1'b0; d_read = 1'b0;
    step;
    chk("stv i_after", m_addr, 64'h308);
    m_ack = 1'b1;
    step;
    m_ack = 1'b0; i_req = 1'b0;
    step;

`ifdef ARB_TIMEOUT_EN
    d_read = 1'b1; d_addr = 64'h600;
    step;
    chk("to m_req", m_req, 1);
    for (int c = 0; c < 7; c++) begin
      step;
      chk($sformatf("to hold%0d", c), {m_req, d_valid}, 2'b10);
    end
    step;
    chk("to m_req_drop", m_req, 0);
    chk("to d_valid", d_valid, 1);
    chk("to d_rdata", d_rdata, 0);
    chk("to bus_err", bus_err, 1);
    d_read = 1'b0;
    step;
    chk("to d_valid_once", d_valid, 0);
    chk("to bus_err_sticky", bus_err, 1);
`else
    chk("no_to bus_err", bus_err, 0);
`endif

    // Async reset in the middle of a D transaction.
    d_read = 1'b1; d_addr = 64'h500;
    step;
    chk("ar m_req_before", m_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar m_req_async", m_req, 0);
    chk("ar m_addr_async", m_addr, 0);
    chk("ar bus_err_clear", bus_err, 0);
    d_read = 1'b0; m_ack = 1'b1;
    step;
    reset = 1'b0;
    begin
      bit quiet = 1'b1;
      for (int c = 0; c < 4; c++) begin
        step;
        if (d_valid !== 1'b0 || i_valid !== 1'b0 || m_req !== 1'b0) quiet = 1'b0;
      end
      chk("ar no_valid_after", quiet, 1);
    end
    m_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
